// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: request/grant/response handshake to the data memory bus,
// byte-enable and lane generation, load extension. Optional: LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata_out,
  output logic              done,
  output logic              timeout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {W_BYTE, W_HALF, W_WORD} width_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  function automatic width_t width_of(input logic [2:0] s);
    case (s)
      3'b001, 3'b100: return W_BYTE;
      3'b010, 3'b101: return W_HALF;
      default:        return W_WORD;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                to_q, to_d;
  logic                mis_q, mis_d;

  width_t              in_w, req_w;
  logic [ADDR_W-1:0]   addr_al;
  logic                mis_in;
  logic                cnt_hit;
  logic [31:0]         lane;
  logic [31:0]         load_ext;
  logic [3:0]          be_req;
  logic [31:0]         wdata_rep;

  always_comb begin
    in_w    = width_of(size);
    req_w   = width_of(size_q);
    addr_al = addr;
    mis_in  = 1'b0;
    if (in_w == W_HALF) begin
      addr_al[0] = 1'b0;
      mis_in     = addr[0];
    end else if (in_w == W_WORD) begin
      addr_al[1:0] = 2'b00;
      mis_in       = |addr[1:0];
    end

    // Checked against the cycle index, not an exact match, so a load granted on
    // the last allowed REQ cycle still aborts if its data does not follow at once.
    cnt_hit = (TIMEOUT > 0) && (cnt_q >= CNT_LAST);

    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      3'b001:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b010:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = lane;
    endcase

    case (req_w)
      W_BYTE: begin
        be_req    = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      W_HALF: begin
        be_req    = 4'b0011 << {addr_q[1], 1'b0};
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be_req    = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  // NOTE: every next-state value gets its hold default before the case, so no
  // path through the block can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    to_d    = to_q;
    mis_d   = mis_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        to_d  = 1'b0;
        mis_d = 1'b0;
        if (rd_en || wr_en) begin
          addr_d  = addr_al;
          size_d  = size;
          wdata_d = wdata;
          we_d    = wr_en;
          state_d = S_REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          if (mis_in) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
            if (!wr_en) rdata_d = '0;
          end
`endif
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (cnt_hit) begin
          state_d = S_DONE;
          to_d    = 1'b1;
          rdata_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          rdata_d = load_ext;
          state_d = S_DONE;
        end else if (cnt_hit) begin
          state_d = S_DONE;
          to_d    = 1'b1;
          rdata_d = '0;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      to_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
      mis_q   <= mis_d;
    end
  end

  // Bus fields are driven only while requesting so they read zero otherwise.
  always_comb begin
    mem_req   = (state_q == S_REQ);
    mem_we    = mem_req & we_q;
    mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_be    = mem_req ? be_req : 4'b0000;
    mem_wdata = mem_req ? wdata_rep : 32'h0;
    done      = (state_q == S_DONE);
    timeout   = done & to_q;
  end

  assign stall     = (rd_en | wr_en) & (state_q != S_DONE);
  assign rdata_out = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = done & mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q ^ mis_in;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized + directed bench for lsu_mem_ctrl against a transaction-level model.
module tb_lsu_mem_ctrl;

  localparam int TO_MAIN = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [2:0]  size;
  logic [31:0] addr, wdata;
  logic        stall, done, timeout, mem_req, mem_we;
  logic [31:0] rdata_out, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
  logic        t4_misalign;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        t4_rd_en, t4_wr_en;
  logic [2:0]  t4_size;
  logic [31:0] t4_addr, t4_wdata;
  logic        t4_stall, t4_done, t4_timeout, t4_mem_req, t4_mem_we;
  logic [31:0] t4_rdata_out, t4_mem_addr, t4_mem_wdata;
  logic [3:0]  t4_mem_be;
  logic        t4_gnt, t4_rvalid;
  logic [31:0] t4_rdata;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(TO_MAIN)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .size(size),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata_out(rdata_out),
    .done(done), .timeout(timeout), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst(rst), .rd_en(t4_rd_en), .wr_en(t4_wr_en), .size(t4_size),
    .addr(t4_addr), .wdata(t4_wdata), .stall(t4_stall), .rdata_out(t4_rdata_out),
    .done(t4_done), .timeout(t4_timeout), .mem_req(t4_mem_req), .mem_we(t4_mem_we),
    .mem_addr(t4_mem_addr), .mem_be(t4_mem_be), .mem_wdata(t4_mem_wdata),
    .mem_gnt(t4_gnt), .mem_rvalid(t4_rvalid), .mem_rdata(t4_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign(t4_misalign)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input logic [2:0] s);
    case (s)
      3'b001, 3'b100: return 1;
      3'b010, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // One access from the decoder's view; gdly = REQ cycles before gnt,
  // rdly = WAIT cycles before rvalid.
  task automatic do_access(input bit is_wr, input bit both, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gdly, input int rdly, input logic [31:0] word);
    int          w, off, g, busy, end_k, r, cyc, reqc, waitc;
    logic [31:0] eff, e_addr, e_wd, lane, v;
    logic [3:0]  e_be;
    bit          mis, timed, fin, granted;

    w      = width_of(sz);
    eff    = a & ~(32'(w) - 32'd1);
    mis    = (a % w) != 0;
    off    = int'(eff % 4);
    e_addr = eff & ~32'd3;
    e_be   = 4'(((1 << w) - 1) << off);
    case (w)
      1:       e_wd = (wd & 32'hFF) * 32'h01010101;
      2:       e_wd = (wd & 32'hFFFF) * 32'h00010001;
      default: e_wd = wd;
    endcase
    lane = word >> (8 * off);
    case (sz)
      3'b001: begin v = lane & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'b010: begin v = lane & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'b100: v = lane & 32'hFF;
      3'b101: v = lane & 32'hFFFF;
      default: v = lane;
    endcase

    timed = 1'b0;
    if (TRAP && mis) begin
      busy = 0;
      if (!is_wr) exp_rdata = 32'h0;
    end else begin
      g = gdly + 1;
      if (g > TO_MAIN) begin
        timed = 1'b1; busy = TO_MAIN;
      end else if (is_wr) begin
        busy = g;
      end else begin
        r     = g + rdly + 1;
        end_k = (g + 1 > TO_MAIN) ? g + 1 : TO_MAIN;
        if (r <= end_k) busy = r;
        else begin timed = 1'b1; busy = end_k; end
      end
      if (timed) exp_rdata = 32'h0;
      else if (!is_wr) exp_rdata = v;
    end

    @(negedge clk);
    wr_en = is_wr; rd_en = !is_wr || both;
    size = sz; addr = a; wdata = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    check("idle_stall", 32'(stall), 32'd1);
    check("idle_req", 32'(mem_req), 32'd0);

    cyc = 0; reqc = 0; waitc = 0; fin = 1'b0; granted = 1'b0;
    while (!fin && cyc < 64) begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      #1;
      cyc++;
      if (done) begin
        fin = 1'b1;
      end else begin
        check("busy_stall", 32'(stall), 32'd1);
        if (mem_req) begin
          reqc++;
          check("req_addr", mem_addr, e_addr);
          check("req_be", 32'(mem_be), 32'(e_be));
          check("req_we", 32'(mem_we), 32'(is_wr));
          if (is_wr) check("req_wdata", mem_wdata, e_wd);
          if (reqc == gdly + 1) begin
            mem_gnt = 1'b1; granted = 1'b1;
            mem_rvalid = 1'($urandom_range(0, 1));
          end
        end else begin
          check("wait_after_gnt", 32'(granted && !is_wr), 32'd1);
          waitc++;
          if (waitc == rdly + 1) begin
            mem_rvalid = 1'b1; mem_rdata = word;
          end
        end
      end
    end

    if (!fin) begin
      check("done_seen", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(cyc), 32'(busy + 1));
      check("done_stall", 32'(stall), 32'd0);
      check("done_timeout", 32'(timeout), 32'(timed));
      check("done_rdata", rdata_out, exp_rdata);
`ifdef LSU_MISALIGN_TRAP_EN
      check("done_misalign", 32'(misalign), 32'(mis));
`endif
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;

    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
    check("post_done", 32'(done), 32'd0);
    check("post_req", 32'(mem_req), 32'd0);
    check("post_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;

    rst = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; size = 3'b011; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    t4_rd_en = 1'b0; t4_wr_en = 1'b0; t4_size = 3'b010; t4_addr = 32'h40;
    t4_wdata = '0; t4_gnt = 1'b0; t4_rvalid = 1'b0; t4_rdata = '0;
    #12;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_access(1, 0, 3'b011, 32'h104, 32'hDEADBEEF, 0, 0, 32'h0);
    do_access(1, 1, 3'b001, 32'h203, 32'h000000A5, 0, 0, 32'h0);
    do_access(0, 0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h00800000);
    check("ld_byte_s", rdata_out, 32'hFFFFFF80);
    do_access(0, 0, 3'b100, 32'h102, 32'h0, 0, 1, 32'h00800000);
    check("ld_byte_u", rdata_out, 32'h00000080);
    do_access(0, 0, 3'b010, 32'h106, 32'h0, 5, 0, 32'h8001_7FFF);
    do_access(0, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'hA1B2C3D4);
    do_access(1, 0, 3'b011, 32'h10A, 32'h12345678, 2, 0, 32'h0);

    for (int i = 0; i < 80; i++) begin
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), $urandom, $urandom,
                int'($urandom_range(0, 9)), int'($urandom_range(0, 6)), $urandom);
    end

    // Timeout with a bus that never grants.
    @(negedge clk);
    t4_rd_en = 1'b1;
    n = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (t4_done) begin
        seen = 1'b1;
        check("t4_req_cycles", 32'(n), 32'd4);
        check("t4_timeout", 32'(t4_timeout), 32'd1);
        check("t4_rdata", t4_rdata_out, 32'd0);
        check("t4_req_at_done", 32'(t4_mem_req), 32'd0);
        t4_rd_en = 1'b0;
      end else if (t4_mem_req) begin
        n++;
      end
    end
    if (!seen) check("t4_done_seen", 32'd0, 32'd1);
    t4_rd_en = 1'b0;
    @(negedge clk);
    #1;
    check("t4_idle_done", 32'(t4_done), 32'd0);
    check("t4_idle_stall", 32'(t4_stall), 32'd0);

    // Reset while a load sits in WAIT.
    do_access(0, 0, 3'b011, 32'h80, 32'h0, 0, 0, 32'h5A5A0F0F);
    @(negedge clk);
    rd_en = 1'b1; size = 3'b011; addr = 32'h300;
    @(negedge clk);
    #1;
    check("rw_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check("rw_wait_noreq", 32'(mem_req), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rw_rst_req", 32'(mem_req), 32'd0);
    check("rw_rst_rdata", rdata_out, 32'd0);
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    #1;
    check("rw_post_req", 32'(mem_req), 32'd0);
    check("rw_post_stall", 32'(stall), 32'd0);
    check("rw_post_done", 32'(done), 32'd0);
    check("rw_post_rdata", rdata_out, 32'd0);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    exp_rdata = 32'h0;
    do_access(0, 0, 3'b101, 32'h302, 32'h0, 1, 2, 32'hBEEF1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
